// File: rtl/axis_downsize_pkg.sv
// Shared constants, state encoding and lane-order helpers for the byte-stream down-sizer.
package axis_downsize_pkg;

  localparam int BYTE = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Maps an emission-order position to a lane index; the mapping is its own inverse.
  function automatic int lane_order(input int pos, input int width, input bit lsb_first);
    return lsb_first ? pos : width - 1 - pos;
  endfunction

  function automatic int tail_lane(input int width, input bit lsb_first);
    return lane_order(width - 1, width, lsb_first);
  endfunction

endpackage

// File: rtl/axis_downsize_lane_next.sv
// Priority search for the next lane to emit, walking lanes in emission order.
// A beat with tlast always emits its tail lane so the packet end is never lost.
module axis_lane_next
  import axis_downsize_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1,
  localparam int IW       = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] keep_i,
  input  logic [IW-1:0]    idx_i,
  input  logic             start_i,
  input  logic             last_i,
  output logic [IW-1:0]    next_o,
  output logic             final_o
);

  localparam logic [WIDTH-1:0] TAIL_MASK =
    {{(WIDTH-1){1'b0}}, 1'b1} << tail_lane(WIDTH, LSB_FIRST);

  logic [WIDTH-1:0] emit;
  logic [IW-1:0]    cur_pos;
  logic [WIDTH-1:0] cand;
  logic [WIDTH:0]   seen;
  logic [IW-1:0]    pick [WIDTH+1];

  assign emit    = last_i ? (keep_i | TAIL_MASK) : keep_i;
  assign cur_pos = LSB_FIRST ? idx_i : IW'(WIDTH - 1) - idx_i;
  assign seen[0] = 1'b0;
  assign pick[0] = '0;

  // seen/pick form a ripple chain so the earliest candidate in emission order wins.
  for (genvar p = 0; p < WIDTH; p++) begin : g_pos
    localparam int LANE = lane_order(p, WIDTH, LSB_FIRST);
    assign cand[p]   = emit[LANE] && (start_i || (IW'(p) > cur_pos));
    assign seen[p+1] = seen[p] | cand[p];
    assign pick[p+1] = pick[p] | ((cand[p] && !seen[p]) ? IW'(LANE) : '0);
  end

  assign next_o  = pick[WIDTH];
  assign final_o = !seen[WIDTH];

endmodule

// File: rtl/axis_downsize.sv
// AXI4-Stream width-down converter: serialises a WIDTH-byte beat into single bytes,
// optionally skipping null lanes while still carrying tlast on a forced null tail byte.
module axis_downsize
  import axis_downsize_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit SKIP      = 1'b1,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  input  logic [WIDTH-1:0]      s_tkeep,
  input  logic [BYTE*WIDTH-1:0] s_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  m_tkeep,
  output logic [BYTE-1:0]       m_tdata
);

  localparam int IW = $clog2(WIDTH);

  state_e                  state_q, state_d;
  logic [BYTE*WIDTH-1:0]   data_q, data_d;
  logic [WIDTH-1:0]        keep_q, keep_d;
  logic                    last_q, last_d;
  logic [IW-1:0]           idx_q, idx_d;

  logic [BYTE-1:0]         lane_q [WIDTH];
  logic [WIDTH-1:0]        held_mask, load_mask;
  logic [IW-1:0]           held_next, load_first;
  logic                    held_final, load_empty;
  logic                    busy, accept;

  for (genvar l = 0; l < WIDTH; l++) begin : g_lane
    assign lane_q[l] = data_q[l*BYTE +: BYTE];
  end

  // Without skipping every lane is emitted, so the search sees an all-ones mask.
  assign held_mask = SKIP ? keep_q  : '1;
  assign load_mask = SKIP ? s_tkeep : '1;

  axis_lane_next #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_held_next (
    .keep_i  (held_mask),
    .idx_i   (idx_q),
    .start_i (1'b0),
    .last_i  (last_q),
    .next_o  (held_next),
    .final_o (held_final)
  );

  axis_lane_next #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_load_first (
    .keep_i  (load_mask),
    .idx_i   ('0),
    .start_i (1'b1),
    .last_i  (s_tlast),
    .next_o  (load_first),
    .final_o (load_empty)
  );

  assign busy     = (state_q == ST_SHIFT);
  assign s_tready = !busy || (m_tready && held_final);
  assign accept   = s_tvalid && s_tready;

  assign m_tvalid = busy;
  assign m_tdata  = lane_q[idx_q];
  assign m_tkeep  = busy && keep_q[idx_q];
  assign m_tlast  = busy && last_q && held_final;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    idx_d   = idx_q;
    if (accept) begin
      data_d  = s_tdata;
      keep_d  = s_tkeep;
      last_d  = s_tlast;
      idx_d   = load_first;
      // A beat with nothing to emit is swallowed without entering SHIFT.
      state_d = load_empty ? ST_IDLE : ST_SHIFT;
    end else if (busy && m_tready) begin
      if (held_final) begin
        state_d = ST_IDLE;
      end else begin
        idx_d = held_next;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_axis_downsize.sv
// Scoreboard bench for axis_downsize: skipping LSB-first instance plus a verbatim MSB-first instance.
module tb_axis_downsize;

  typedef struct packed {
    logic [7:0] d;
    logic       k;
    logic       l;
  } item_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: SKIP=1, LSB_FIRST=1
  logic        rst_n;
  logic        s_tvalid, s_tready, s_tlast;
  logic [3:0]  s_tkeep;
  logic [31:0] s_tdata;
  logic        m_tvalid, m_tready, m_tlast, m_tkeep;
  logic [7:0]  m_tdata;

  // Instance B: SKIP=0, LSB_FIRST=0
  logic        b_rst_n;
  logic        b_s_tvalid, b_s_tready, b_s_tlast;
  logic [3:0]  b_s_tkeep;
  logic [31:0] b_s_tdata;
  logic        b_m_tvalid, b_m_tready, b_m_tlast, b_m_tkeep;
  logic [7:0]  b_m_tdata;

  axis_downsize #(.WIDTH(4), .SKIP(1'b1), .LSB_FIRST(1'b1)) dut_a (
    .clock(clk), .reset_n(rst_n),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .s_tkeep(s_tkeep), .s_tdata(s_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .m_tkeep(m_tkeep), .m_tdata(m_tdata)
  );

  axis_downsize #(.WIDTH(4), .SKIP(1'b0), .LSB_FIRST(1'b0)) dut_b (
    .clock(clk), .reset_n(b_rst_n),
    .s_tvalid(b_s_tvalid), .s_tready(b_s_tready), .s_tlast(b_s_tlast),
    .s_tkeep(b_s_tkeep), .s_tdata(b_s_tdata),
    .m_tvalid(b_m_tvalid), .m_tready(b_m_tready), .m_tlast(b_m_tlast),
    .m_tkeep(b_m_tkeep), .m_tdata(b_m_tdata)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  item_t exp_q[$];
  int    pops = 0, tlast_seen = 0, vld_cycles = 0;
  bit    rand_rdy = 1'b0;
  bit    b_done = 1'b0;
  logic  prev_stall = 1'b0;
  item_t prev_out, mon_e, mon_act;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: kept lanes in order; a tlast beat whose top lane is null adds that lane as a null byte.
  function automatic void model_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    item_t out[$];
    item_t it;
    for (int lane = 0; lane < 4; lane++) begin
      if (k[lane]) begin
        it.d = d[8*lane +: 8]; it.k = 1'b1; it.l = 1'b0;
        out.push_back(it);
      end
    end
    if (l && !k[3]) begin
      it.d = d[31:24]; it.k = 1'b0; it.l = 1'b0;
      out.push_back(it);
    end
    if (l && out.size() > 0) out[out.size()-1].l = 1'b1;
    foreach (out[i]) exp_q.push_back(out[i]);
  endfunction

  always @(posedge clk) begin
    #1;
    m_tready = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  // Monitor: compares each transfer against the scoreboard and checks stall stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      mon_act = {m_tdata, m_tkeep, m_tlast};
      if (m_tvalid) vld_cycles++;
      if (prev_stall) begin
        check("stall_valid", 32'(m_tvalid), 32'd1);
        check("stall_hold", 32'(mon_act), 32'(prev_out));
      end
      if (m_tvalid && m_tready) begin
        pops++;
        if (m_tlast) tlast_seen++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out: got 0x%0h, expected no output at %0t", mon_act, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_byte", 32'(mon_act), 32'(mon_e));
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_out   = mon_act;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    s_tvalid = 1'b1; s_tdata = d; s_tkeep = k; s_tlast = l;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_tready) begin
        model_beat(d, k, l);
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        return;
      end
    end
    check("accept_timeout", 32'd0, 32'd1);
    s_tvalid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0) break;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("idle_after_drain", 32'(m_tvalid), 32'd0);
    @(posedge clk); #1;
  endtask

  // Instance B: drives one beat and checks four bytes in MSB-first order with s_tready timing.
  task automatic b_beat(input logic [31:0] d, input logic [3:0] k, input logic [31:0] exp_d,
                        input logic [3:0] exp_k);
    b_s_tvalid = 1'b1; b_s_tdata = d; b_s_tkeep = k; b_s_tlast = 1'b1;
    @(negedge clk);
    check("B_accept_ready", 32'(b_s_tready), 32'd1);
    @(posedge clk); #1;
    b_s_tvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("B_valid", 32'(b_m_tvalid), 32'd1);
      check("B_data", 32'(b_m_tdata), 32'(exp_d[8*i +: 8]));
      check("B_keep", 32'(b_m_tkeep), 32'(exp_k[i]));
      check("B_last", 32'(b_m_tlast), (i == 3) ? 32'd1 : 32'd0);
      check("B_s_tready", 32'(b_s_tready), (i == 3) ? 32'd1 : 32'd0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    b_rst_n = 1'b0; b_s_tvalid = 1'b0; b_s_tlast = 1'b0;
    b_s_tkeep = '0; b_s_tdata = '0; b_m_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) b_rst_n = 1'b1;
    @(posedge clk); #1;
    b_beat(32'h44332211, 4'b1111, 32'h11223344, 4'b1111);
    b_beat(32'hDDCCBBAA, 4'b0101, 32'hAABBCCDD, 4'b1010);
    b_done = 1'b1;
  end

  initial begin
    int base, pkts, nb;
    rst_n = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tkeep = '0; s_tdata = '0;
    m_tready = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_m_tlast", 32'(m_tlast), 32'd0);
    check("rst_m_tkeep", 32'(m_tkeep), 32'd0);
    check("rst_s_tready", 32'(s_tready), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Sparse non-last beat followed back-to-back by a full last beat: six busy cycles, no bubble.
    base = vld_cycles;
    send_beat(32'hDDCCBBAA, 4'b0101, 1'b0);
    send_beat(32'h87654321, 4'b1111, 1'b1);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0) break;
    end
    check("no_bubble_cycles", 32'(vld_cycles - base), 32'd6);
    wait_drain(50);

    // Two kept lanes then a forced null tail byte carrying tlast.
    send_beat(32'h5A4B3C2D, 4'b0011, 1'b1);
    wait_drain(50);

    // Empty non-last beat is swallowed silently; empty last beat gives one null tlast byte.
    send_beat(32'hCAFEF00D, 4'b0000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("null_beat_silent", 32'(m_tvalid), 32'd0);
      check("null_beat_ready", 32'(s_tready), 32'd1);
    end
    @(posedge clk); #1;
    send_beat(32'hBEEF0000, 4'b0000, 1'b1);
    wait_drain(50);

    // Random packets under random backpressure.
    rand_rdy = 1'b1;
    base = tlast_seen;
    pkts = 0;
    for (int p = 0; p < 200; p++) begin
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
        end
        send_beat($urandom, 4'($urandom_range(0, 15)), (b == nb - 1));
      end
      pkts++;
    end
    wait_drain(20000);
    check("tlast_count", 32'(tlast_seen - base), 32'(pkts));

    // Asynchronous reset while the third lane of a beat is being presented.
    rand_rdy = 1'b0;
    @(posedge clk); #1;
    base = pops;
    send_beat(32'h0D0C0B0A, 4'b1111, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      if (pops >= base + 2) break;
    end
    #2;
    check("pre_reset_valid", 32'(m_tvalid), 32'd1);
    check("pre_reset_data", 32'(m_tdata), 32'h0C);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(m_tvalid), 32'd0);
    check("async_rst_ready", 32'(s_tready), 32'd1);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", 32'(s_tready), 32'd1);
    check("post_rst_valid", 32'(m_tvalid), 32'd0);
    check("post_rst_last", 32'(m_tlast), 32'd0);
    send_beat(32'h44332211, 4'b1111, 1'b0);
    send_beat(32'h00FF00EE, 4'b0101, 1'b1);
    wait_drain(100);

    for (int i = 0; i < 1000; i++) begin
      if (b_done) break;
      @(posedge clk);
    end
    check("B_done", 32'(b_done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
